shift_sequencer: RTL

Multi-cycle shift controller that drives the single-bit 16-bit shift stage to perform shifts of 0–15 positions. It accepts one request at a time from the datapath control, captures the operand, operation and amount, and applies one single-bit step per clock. It reports completion with a one-cycle `done` pulse and holds the result until the next accepted request. It sits between the instruction decoder/ALU control and the register-file writeback path.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_step.sv | 23 ++
 rtl/shift_sequencer.sv | 90 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// Op encoding is common to the sequencer and its single-step shifter.
package shift_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AMT_W_DEF = 4;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift of a WIDTH-bit word.
// The shift direction and fill bit are selected by the 2-bit op.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_comb begin
        o_q = i_d;
        case (i_op)
            SH_LSL:  o_q = {i_d[WIDTH-2:0], 1'b0};
            SH_LSR:  o_q = {1'b0, i_d[WIDTH-1:1]};
            SH_ASR:  o_q = {i_d[WIDTH-1], i_d[WIDTH-1:1]};
            default: o_q = i_d;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: captures one request, applies one
// single-bit step per clock, then pulses done and holds the result.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [AMT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   w_step;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_op (r_op),
        .i_d  (r_data),
        .o_q  (w_step)
    );

    // busy/done are registered alongside the state they mirror
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_op    <= SH_NONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_data <= b_in;
                        r_op   <= op;
                        r_cnt  <= amount;
                        r_busy <= 1'b1;
                        if (amount == '0 || op == SH_NONE) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_data <= w_step;
                    r_cnt  <= r_cnt - AMT_W'(1);
                    r_busy <= 1'b1;
                    if (r_cnt == AMT_W'(1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_data;

endmodule
